// File: rtl/sq_dist_pkg.sv
// Shared definitions for the squared-magnitude comparator: relation encodings,
// the mode type and the sum-width helper.
package sq_dist_pkg;

   typedef logic [1:0] sq_mode_t;

   localparam sq_mode_t SQ_GT = 2'b00;
   localparam sq_mode_t SQ_GE = 2'b01;
   localparam sq_mode_t SQ_LT = 2'b10;
   localparam sq_mode_t SQ_EQ = 2'b11;

   // Width that holds the sum of ch squares of w-bit values without overflow.
   function automatic int sq_sw(input int w, input int ch);
      return 2 * w + $clog2(ch);
   endfunction

endpackage

// File: rtl/sq_dist_lane.sv
// One vector component squared into a registered 2W-bit result.
// Define SQ_DIST_SIGNED_EN to treat the component as two's complement.
module sq_dist_lane #(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           en,
   input  logic [W-1:0]   a,
   output logic [2*W-1:0] sq
);

   logic [2*W-1:0] a_ext;
   logic [2*W-1:0] sq_reg;

   // The low 2W bits of the extended product are the exact square in both modes.
`ifdef SQ_DIST_SIGNED_EN
   assign a_ext = {{W{a[W-1]}}, a};
`else
   assign a_ext = {{W{1'b0}}, a};
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         sq_reg <= '0;
      end else if (en) begin
         sq_reg <= a_ext * a_ext;
      end
   end

   assign sq = sq_reg;

endmodule

// File: rtl/sq_dist_cmp.sv
// Three-stage pipelined sum-of-squares comparator with valid/ready flow control.
// Define SQ_DIST_SIGNED_EN for two's-complement components.
module sq_dist_cmp
   import sq_dist_pkg::*;
#(
   parameter int W  = 32,
   parameter int CH = 3,
   parameter int SW = sq_sw(W, CH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [CH*W-1:0] in_a,
   input  logic [SW-1:0]   in_c,
   input  sq_mode_t        in_mode,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_r,
   output logic [SW-1:0]   out_sum
);

   logic           adv;
   logic           s1_valid_reg;
   logic           s2_valid_reg;
   logic           out_valid_reg;
   logic [2*W-1:0] sq_reg [CH];
   logic [SW-1:0]  c1_reg;
   logic [SW-1:0]  c2_reg;
   logic [SW-1:0]  sum2_reg;
   logic [SW-1:0]  sum_next;
   logic [SW-1:0]  out_sum_reg;
   sq_mode_t       mode1_reg;
   sq_mode_t       mode2_reg;
   logic           r_next;
   logic           out_r_reg;

   // The whole pipe moves as one unit; a stalled output freezes every stage.
   assign adv      = !out_valid_reg || out_ready;
   assign in_ready = adv;

   generate
      for (genvar gi = 0; gi < CH; gi++) begin : g_lane
         sq_dist_lane #(.W(W)) u_lane (
            .clk (clk),
            .rst (rst),
            .en  (adv),
            .a   (in_a[gi*W +: W]),
            .sq  (sq_reg[gi])
         );
      end
   endgenerate

   always_comb begin
      sum_next = '0;
      for (int k = 0; k < CH; k++) begin
         sum_next = sum_next + SW'(sq_reg[k]);
      end
   end

   always_comb begin
      r_next = 1'b0;
      case (mode2_reg)
         SQ_GT:   r_next = (sum2_reg >  c2_reg);
         SQ_GE:   r_next = (sum2_reg >= c2_reg);
         SQ_LT:   r_next = (sum2_reg <  c2_reg);
         default: r_next = (sum2_reg == c2_reg);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg  <= 1'b0;
         s2_valid_reg  <= 1'b0;
         out_valid_reg <= 1'b0;
         c1_reg        <= '0;
         c2_reg        <= '0;
         mode1_reg     <= SQ_GT;
         mode2_reg     <= SQ_GT;
         sum2_reg      <= '0;
         out_r_reg     <= 1'b0;
         out_sum_reg   <= '0;
      end else if (adv) begin
         s1_valid_reg  <= in_valid;
         c1_reg        <= in_c;
         mode1_reg     <= in_mode;
         s2_valid_reg  <= s1_valid_reg;
         sum2_reg      <= sum_next;
         c2_reg        <= c1_reg;
         mode2_reg     <= mode1_reg;
         out_valid_reg <= s2_valid_reg;
         out_r_reg     <= r_next;
         out_sum_reg   <= sum2_reg;
      end
   end

   assign out_valid = out_valid_reg;
   assign out_r     = out_r_reg;
   assign out_sum   = out_sum_reg;

endmodule

// File: tb/tb_sq_dist_cmp.sv
// Randomised and directed checks of sq_dist_cmp against a scoreboard model;
// follows SQ_DIST_SIGNED_EN for the component interpretation.
module tb_sq_dist_cmp;
   import sq_dist_pkg::*;

   localparam int W  = 32;
   localparam int CH = 3;
   localparam int SW = sq_sw(W, CH);

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [CH*W-1:0] in_a = '0;
   logic [SW-1:0]   in_c = '0;
   sq_mode_t        in_mode = SQ_GT;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic            out_r;
   logic [SW-1:0]   out_sum;

   sq_dist_cmp #(.W(W), .CH(CH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_c      (in_c),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_r     (out_r),
      .out_sum   (out_sum)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [SW-1:0] sum;
      logic          r;
   } res_t;

   res_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_acc   = 0;

   task automatic check(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, want);
      end
   endtask

   // Reference: the arithmetic sum of component magnitudes squared, then the relation.
   function automatic res_t model(input logic [CH*W-1:0] a, input logic [SW-1:0] c, input sq_mode_t m);
      res_t          res;
      logic [W-1:0]  comp;
      logic [SW-1:0] mag;
      logic [SW-1:0] s;
      s = '0;
      for (int k = 0; k < CH; k++) begin
         comp = a[k*W +: W];
`ifdef SQ_DIST_SIGNED_EN
         if (comp[W-1]) comp = ~comp + 1'b1;
`endif
         mag = SW'(comp);
         s = s + mag * mag;
      end
      res.sum = s;
      case (m)
         SQ_GT:   res.r = s >  c;
         SQ_GE:   res.r = s >= c;
         SQ_LT:   res.r = s <  c;
         default: res.r = s == c;
      endcase
      return res;
   endfunction

   // Inputs are driven at the falling edge; this settles them, scores the edge, advances.
   task automatic cycle();
      res_t e;
      #1;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_result", 1, 0);
         end else begin
            e = exp_q.pop_front();
            $display("[TB] result sum=%0h r=%0b (expected sum=%0h r=%0b)", out_sum, out_r, e.sum, e.r);
            check("sum", out_sum, e.sum);
            check("r", out_r, e.r);
         end
      end
      if (!rst && in_valid && in_ready) begin
         exp_q.push_back(model(in_a, in_c, in_mode));
         n_acc++;
      end
      @(negedge clk);
   endtask

   task automatic send(input logic [CH*W-1:0] a, input logic [SW-1:0] c, input sq_mode_t m);
      int start;
      start    = n_acc;
      in_valid = 1'b1;
      in_a     = a;
      in_c     = c;
      in_mode  = m;
      for (int t = 0; t < 10 && n_acc == start; t++) cycle();
      if (n_acc == start) check("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int t = 0; t < 20 && exp_q.size() > 0; t++) cycle();
      check("drain_empty", SW'(exp_q.size()), 0);
   endtask

   function automatic logic [W-1:0] rand_comp();
      case ($urandom_range(0, 3))
         0:       return '0;
         1:       return '1;
         2:       return W'($urandom_range(0, 15));
         default: return W'($urandom);
      endcase
   endfunction

   logic [CH*W-1:0] va;
   logic [SW-1:0]   cmax;
   logic [SW-1:0]   held_sum;
   logic            held_r;
   res_t            probe;
   int              stall_left;
   bit              seen;

   initial begin
      // Reset state
      @(negedge clk);
      cycle();
      cycle();
      rst = 1'b0;
      check("rst_out_valid", out_valid, 0);
      check("rst_out_r", out_r, 0);
      check("rst_out_sum", out_sum, 0);

      // Basic GT with latency probe
      va = {32'd0, 32'd4, 32'd3};
      send(va, 24, SQ_GT);
      check("lat1_valid", out_valid, 0);
      cycle();
      check("lat2_valid", out_valid, 0);
      cycle();
      check("lat3_valid", out_valid, 1);
      check("basic_sum", out_sum, 25);
      check("basic_gt", out_r, 1);
      cycle();

      // Relations at the equality point
      send(va, 25, SQ_GT);
      send(va, 25, SQ_GE);
      send(va, 25, SQ_LT);
      send(va, 25, SQ_EQ);
      // Zero vector against zero threshold
      send('0, 0, SQ_GT);
      send('0, 0, SQ_GE);
      send('0, 0, SQ_LT);
      send('0, 0, SQ_EQ);
      // All components at their maximum code
      cmax = SW'(32'hFFFF_FFFF) * SW'(32'hFFFF_FFFF) * SW'(3);
      send('1, cmax, SQ_GE);
      send('1, cmax, SQ_GT);
      // Most-negative / minus-one bit pattern
      send({32'd0, 32'h8000_0000, 32'hFFFF_FFFF}, 0, SQ_GE);
      drain();

      // Backpressure: six back-to-back beats, output held off for five cycles
      stall_left = 5;
      seen       = 1'b0;
      begin
         int start;
         start = n_acc;
         for (int t = 0; t < 60 && (n_acc - start < 6 || exp_q.size() > 0); t++) begin
            in_valid = (n_acc - start < 6);
            for (int k = 0; k < CH; k++) in_a[k*W +: W] = rand_comp();
            in_c    = {$urandom, $urandom, $urandom};
            in_mode = sq_mode_t'($urandom_range(0, 3));
            if (out_valid && !seen) begin
               seen     = 1'b1;
               held_sum = out_sum;
               held_r   = out_r;
            end
            out_ready = !(seen && stall_left > 0);
            #1;
            if (!out_ready) begin
               check("stall_in_ready", in_ready, 0);
               check("stall_valid", out_valid, 1);
               check("stall_sum_hold", out_sum, held_sum);
               check("stall_r_hold", out_r, held_r);
               stall_left--;
            end
            cycle();
         end
         check("bp_accepted", SW'(n_acc - start), 6);
      end
      drain();

      // Reset mid-stream with a handshake during reset
      va = {32'd1, 32'd2, 32'd3};
      in_valid = 1'b1;
      in_a     = va;
      cycle();
      cycle();
      rst = 1'b1;
      cycle();
      rst      = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      check("mid_rst_valid", out_valid, 0);
      check("mid_rst_r", out_r, 0);
      check("mid_rst_sum", out_sum, 0);
      for (int t = 0; t < 6; t++) begin
         cycle();
         check("no_stale", out_valid, 0);
      end

      // Randomised traffic with random backpressure
      for (int t = 0; t < 300; t++) begin
         in_valid = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < CH; k++) in_a[k*W +: W] = rand_comp();
         in_mode = sq_mode_t'($urandom_range(0, 3));
         probe   = model(in_a, '0, SQ_GT);
         case ($urandom_range(0, 3))
            0:       in_c = probe.sum;
            1:       in_c = probe.sum + 1'b1;
            2:       in_c = probe.sum - 1'b1;
            default: in_c = {$urandom, $urandom, $urandom};
         endcase
         out_ready = ($urandom_range(0, 3) != 0);
         cycle();
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
